// File: rtl/custom_instr_responder_pkg.sv
// Shared constants and types for the custom-0 instruction responder.
package custom_instr_responder_pkg;

    localparam logic [4:0]  CI_MAJOR_OPCODE   = 5'b00010;
    localparam logic [31:0] CI_DEFAULT_RESULT = 32'hdeadbeef;
    localparam int unsigned FUNCT7_SUB        = 5;

    typedef enum logic [2:0] {
        OpLoad  = 3'd0,
        OpAdd   = 3'd1,
        OpRead  = 3'd2,
        OpMac   = 3'd3,
        OpClear = 3'd4,
        OpCount = 3'd5,
        OpAddi  = 3'd6,
        OpRsvd  = 3'd7
    } minor_op_e;

endpackage

// File: rtl/custom_instr_hart_state.sv
// Private accumulator and saturating invocation counter for one hardware thread.
module custom_instr_hart_state
    import custom_instr_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  minor_op_e             i_op,
    input  logic                  i_sub,
    input  logic [DATA_WIDTH-1:0] i_op1,
    input  logic [DATA_WIDTH-1:0] i_op2,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_cnt
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH-1:0] w_cnt_next;
    logic [DATA_WIDTH-1:0] w_prod;

    // Only the low half of the product is kept.
    assign w_prod = i_op1 * i_op2;

    always_comb begin
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        if (i_en) begin
            if (r_cnt != '1) begin
                w_cnt_next = r_cnt + 1'b1;
            end
            case (i_op)
                OpLoad:  w_acc_next = i_op1;
                OpAdd:   w_acc_next = i_sub ? (r_acc - i_op2) : (r_acc + i_op2);
                OpMac:   w_acc_next = r_acc + w_prod;
                OpClear: begin
                    w_acc_next = '0;
                    w_cnt_next = '0;
                end
                OpAddi:  w_acc_next = r_acc + i_imm;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign o_acc = r_acc;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/custom_instr_responder.sv
// Responder for the core's CustomInstr port: decodes custom-0 ops, updates per-hart
// state and returns a registered result one cycle after issue.
module custom_instr_responder
    import custom_instr_responder_pkg::*;
#(
    parameter int unsigned           HART_COUNT     = 2,
    parameter int unsigned           HID_WIDTH      = 1,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [4:0]            MAJOR_OPCODE   = CI_MAJOR_OPCODE,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RESULT = DATA_WIDTH'(CI_DEFAULT_RESULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CustomInstr_valid_in,
    input  logic [HID_WIDTH-1:0]  CustomInstr_hid_in,
    input  logic [4:0]            CustomInstr_major_opcode_in,
    input  logic [2:0]            CustomInstr_minor_opcode_in,
    input  logic [DATA_WIDTH-1:0] CustomInstr_op1_in,
    input  logic [DATA_WIDTH-1:0] CustomInstr_op2_in,
    input  logic [DATA_WIDTH-1:0] CustomInstr_imm_in,
    input  logic [6:0]            CustomInstr_funct7_in,
    output logic [DATA_WIDTH-1:0] CustomInstr_result_out
);

    minor_op_e             w_op;
    logic                  w_accept;
    logic                  w_sub;
    logic                  w_unused_funct7;
    logic [HART_COUNT-1:0] w_hart_sel;
    logic [DATA_WIDTH-1:0] w_acc [HART_COUNT];
    logic [DATA_WIDTH-1:0] w_cnt [HART_COUNT];
    logic [DATA_WIDTH-1:0] w_sel_acc;
    logic [DATA_WIDTH-1:0] w_sel_cnt;
    logic [DATA_WIDTH-1:0] w_result_next;
    logic [DATA_WIDTH-1:0] r_result;

    assign w_op     = minor_op_e'(CustomInstr_minor_opcode_in);
    assign w_accept = CustomInstr_valid_in
                      && (CustomInstr_major_opcode_in == MAJOR_OPCODE)
                      && (32'(CustomInstr_hid_in) < HART_COUNT);
    assign w_sub    = CustomInstr_funct7_in[FUNCT7_SUB];

    assign w_unused_funct7 = ^{CustomInstr_funct7_in[6:FUNCT7_SUB+1],
                               CustomInstr_funct7_in[FUNCT7_SUB-1:0]};

    for (genvar h = 0; h < HART_COUNT; h++) begin : g_hart
        assign w_hart_sel[h] = (32'(CustomInstr_hid_in) == h);

        custom_instr_hart_state #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_hart_state (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_en    (w_accept && w_hart_sel[h]),
            .i_op    (w_op),
            .i_sub   (w_sub),
            .i_op1   (CustomInstr_op1_in),
            .i_op2   (CustomInstr_op2_in),
            .i_imm   (CustomInstr_imm_in),
            .o_acc   (w_acc[h]),
            .o_cnt   (w_cnt[h])
        );
    end

    always_comb begin
        w_sel_acc = '0;
        w_sel_cnt = '0;
        for (int h = 0; h < HART_COUNT; h++) begin
            if (w_hart_sel[h]) begin
                w_sel_acc = w_acc[h];
                w_sel_cnt = w_cnt[h];
            end
        end
    end

    // Reads see the pre-update state, so COUNT returns the count before its own increment.
    always_comb begin
        w_result_next = DEFAULT_RESULT;
        if (w_accept) begin
            case (w_op)
                OpRead:  w_result_next = w_sel_acc;
                OpCount: w_result_next = w_sel_cnt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result <= DEFAULT_RESULT;
        end else begin
            r_result <= w_result_next;
        end
    end

    assign CustomInstr_result_out = r_result;

endmodule

// File: tb/tb_custom_instr_responder.sv
// Directed bench for custom_instr_responder with a queue-based result scoreboard.
module tb_custom_instr_responder;

    localparam logic [31:0] DEF = 32'hdeadbeef;
    localparam logic [4:0]  MAJ = 5'b00010;

    typedef struct {
        int unsigned due;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [0:0]  hid;
    logic [4:0]  major;
    logic [2:0]  minor;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [6:0]  funct7;
    logic [31:0] result;

    exp_t        q[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    custom_instr_responder u_dut (
        .clk                         (clk),
        .rst                         (rst),
        .CustomInstr_valid_in        (valid),
        .CustomInstr_hid_in          (hid),
        .CustomInstr_major_opcode_in (major),
        .CustomInstr_minor_opcode_in (minor),
        .CustomInstr_op1_in          (op1),
        .CustomInstr_op2_in          (op2),
        .CustomInstr_imm_in          (imm),
        .CustomInstr_funct7_in       (funct7),
        .CustomInstr_result_out      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the result register is presented every cycle; check entries due now.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.due < cyc) begin
                bad++;
                $display("FAIL %s: missed check at cycle %0d (now %0d)", e.name, e.due, cyc);
            end else if (result !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, result, e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [4:0] maj,
                        input logic [2:0] mn, input logic h, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [6:0] f7,
                        input logic [31:0] exp, input string name);
        @(posedge clk);
        #1;
        rst    = r;
        valid  = v;
        major  = maj;
        minor  = mn;
        hid    = h;
        op1    = a;
        op2    = b;
        imm    = im;
        funct7 = f7;
        q.push_back('{due: cyc + 1, exp: exp, name: name});
    endtask

    task automatic op(input logic [2:0] mn, input logic h, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [6:0] f7,
                      input logic [31:0] exp, input string name);
        step(1'b1, 1'b1, MAJ, mn, h, a, b, im, f7, exp, name);
    endtask

    task automatic idle(input logic r, input string name);
        step(r, 1'b0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 7'd0, DEF, name);
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; hid = 1'b0; major = '0; minor = '0;
        op1 = '0; op2 = '0; imm = '0; funct7 = '0;

        // 1: reset hold then first read
        for (int i = 0; i < 10; i++) idle(1'b0, "reset_default");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd0, "t1_read_after_reset");
        idle(1'b1, "t1_revert");

        // 2: back-to-back on hart 0
        op(3'd0, 1'b0, 5, 0, 0, 7'h00, DEF, "t2_load_nores");
        op(3'd1, 1'b0, 0, 7, 0, 7'h00, DEF, "t2_add_nores");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd12, "t2_read_12");
        idle(1'b1, "t2_revert");

        // 3: wrap on hart 1, hart 0 untouched, funct7 bits other than [5] ignored
        op(3'd0, 1'b1, 32'hffffffff, 0, 0, 7'h00, DEF, "t3_load_h1");
        op(3'd1, 1'b1, 0, 2, 0, 7'h00, DEF, "t3_add_h1");
        op(3'd2, 1'b1, 0, 0, 0, 7'h00, 32'd1, "t3_read_h1_wrap");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd12, "t3_read_h0_kept");
        op(3'd1, 1'b1, 0, 3, 0, 7'h5f & 7'h5f & 7'h40, DEF, "t3_add_f7_40");
        op(3'd2, 1'b1, 0, 0, 0, 7'h00, 32'd4, "t3_read_h1_4");

        // 4: clear, mac, addi, sub, read, count
        op(3'd4, 1'b0, 0, 0, 0, 7'h00, DEF, "t4_clear");
        op(3'd3, 1'b0, 3, 4, 0, 7'h00, DEF, "t4_mac");
        op(3'd6, 1'b0, 0, 0, 32'hfffffffe, 7'h00, DEF, "t4_addi");
        op(3'd1, 1'b0, 0, 1, 0, 7'h20, DEF, "t4_sub");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd9, "t4_read_9");
        op(3'd5, 1'b0, 0, 0, 0, 7'h00, 32'd4, "t4_count_4");
        idle(1'b1, "t4_revert");

        // 5: wrong major opcode ignored, reserved minor counted but no acc change
        step(1'b1, 1'b1, 5'b01010, 3'd0, 1'b0, 99, 0, 0, 7'h00, DEF, "t5_bad_major");
        op(3'd7, 1'b0, 99, 99, 99, 7'h00, DEF, "t5_rsvd");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd9, "t5_read_unchanged");
        op(3'd5, 1'b0, 0, 0, 0, 7'h00, 32'd7, "t5_count_7");

        // 6: instruction during reset dropped, state cleared
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd9, "t6_read_before_rst");
        step(1'b0, 1'b1, MAJ, 3'd0, 1'b0, 77, 0, 0, 7'h00, DEF, "t6_load_in_reset");
        op(3'd2, 1'b0, 0, 0, 0, 7'h00, 32'd0, "t6_read_0");
        op(3'd5, 1'b0, 0, 0, 0, 7'h00, 32'd1, "t6_count_1");
        idle(1'b1, "t6_revert");

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected results still pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
